// File: rtl/outbuf_drain_if.sv
// Result-edge write port and host-side valid/ready drain stream
// for the PE-array output buffer.
interface outbuf_drain_if #(
  parameter int WORDLEN = 8
);
  logic               wr_en;
  logic [WORDLEN-1:0] din;
  logic               out_valid;
  logic               out_ready;
  logic [WORDLEN-1:0] dout;

  modport master (
    output wr_en,
    output din,
    output out_ready,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  wr_en,
    input  din,
    input  out_ready,
    output out_valid,
    output dout
  );
endinterface

// File: rtl/outbuf_drain.sv
// Circular output FIFO on the PE-array result edge: drops the
// first SKIP fill words, tracks full/empty exactly, flags overflow.
module outbuf_drain #(
  parameter int WORDLEN   = 8,
  parameter int BUFSIZE   = 16,
  parameter int SKIP      = 0,
  parameter int AFULL_THR = 12
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  outbuf_drain_if.slave bus,
  output logic       full,
  output logic       almost_full,
  output logic [5:0] count,
  output logic       skipping,
  output logic       overflow
);
  localparam int PW = $clog2(BUFSIZE);
  localparam logic [PW-1:0] LAST = PW'(BUFSIZE - 1);
  localparam logic [5:0] DEPTH = 6'(BUFSIZE);
  localparam logic [5:0] AFT = 6'(AFULL_THR);
  localparam logic [7:0] SKIP_INIT = 8'(SKIP);

  logic [WORDLEN-1:0] mem_q [BUFSIZE];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [5:0]         count_q, count_d;
  logic [7:0]         skip_q, skip_d;
  logic               ovf_q, ovf_d;

  logic valid;
  logic pop;
  logic push;
  logic drop;

  assign valid    = (count_q != 6'd0);
  assign full     = (count_q == DEPTH);
  assign skipping = (skip_q != 8'd0);

  // A full FIFO still accepts a write when the head leaves this cycle.
  assign pop  = valid & bus.out_ready;
  assign push = bus.wr_en & ~skipping & (~full | pop);
  assign drop = bus.wr_en & ~skipping & full & ~pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    skip_d  = skip_q;
    ovf_d   = ovf_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      skip_d  = SKIP_INIT;
      ovf_d   = 1'b0;
    end else begin
      if (bus.wr_en && skipping)
        skip_d = skip_q - 8'd1;
      if (push)
        tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      if (pop)
        head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 6'd1;
        2'b01:   count_d = count_q - 6'd1;
        default: count_d = count_q;
      endcase
      if (drop)
        ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      skip_q  <= SKIP_INIT;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      skip_q  <= skip_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem_q[tail_q] <= bus.din;
  end

  assign bus.out_valid = valid;
  assign bus.dout      = valid ? mem_q[head_q] : '0;
  assign almost_full   = (count_q >= AFT);
  assign count         = count_q;
  assign overflow      = ovf_q;
endmodule
